// File: rtl/dmac_pkg.sv
// Shared types and constants for the DMA channel scheduler.
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_BUS = 3'd1,
        START   = 3'd2,
        BUSY    = 3'd3,
        ACK     = 3'd4
    } sched_state_e;

    // Arbitration mode encodings for rr_mode.
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/dmac_rr_picker.sv
// Combinational winner picker: rotate the request vector so the base pointer
// sits at bit 0, find the first set bit, then rotate the index back.
// In fixed mode the base is forced to zero, giving lowest-index priority.
module dmac_rr_picker
    import dmac_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_base,
    input  logic              i_mode,
    output logic              o_valid,
    output logic [CH_W-1:0]   o_idx
);

    logic [CH_W-1:0]   w_base;
    logic [NUM_CH-1:0] w_rot;
    logic [CH_W-1:0]   w_ffs;
    logic [CH_W:0]     w_sum;

    // Rotate, find-first-set, un-rotate.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_base  = (i_mode == ARB_RR) ? i_base : '0;
        w_rot   = NUM_CH'({i_req, i_req} >> w_base);
        w_ffs   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ffs = CH_W'(i);
            end
        end
        w_sum   = {1'b0, w_ffs} + {1'b0, w_base};
        o_idx   = (w_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(w_sum - (CH_W+1)'(NUM_CH))
                                               : CH_W'(w_sum);
        o_valid = |i_req;
    end

endmodule

// File: rtl/dmac_channel_sched.sv
// DMA channel scheduler: picks a requesting channel, owns the master-bus
// request/grant handshake, kicks the datapath, then acks the peripheral and
// records sticky done/error status that feeds a registered interrupt.
module dmac_channel_sched
    import dmac_pkg::*;
#(
    parameter int  NUM_CH = 2,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] DmacReq,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              rr_mode,
    output logic              Bus_Req,
    input  logic              Bus_Grant,
    output logic [CH_W-1:0]   ch_sel,
    output logic              ch_start,
    input  logic              ch_done,
    input  logic              ch_error,
    output logic [NUM_CH-1:0] ReqAck,
    input  logic [NUM_CH-1:0] irq_clr,
    output logic [NUM_CH-1:0] done_sts,
    output logic [NUM_CH-1:0] err_sts,
    output logic              Interrupt
);

    sched_state_e      r_state;
    sched_state_e      w_next_state;
    logic [CH_W-1:0]   r_ch_sel;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_cause_done;
    logic              r_cause_err;
    logic [NUM_CH-1:0] r_done_sts;
    logic [NUM_CH-1:0] r_err_sts;
    logic              r_irq;

    logic [NUM_CH-1:0] w_eligible;
    logic [NUM_CH-1:0] w_sel_onehot;
    logic [NUM_CH-1:0] w_done_set;
    logic [NUM_CH-1:0] w_err_set;
    logic              w_win_valid;
    logic [CH_W-1:0]   w_win_idx;
    logic              w_finish;

    assign w_eligible   = DmacReq & ch_en;
    assign w_sel_onehot = NUM_CH'(1) << r_ch_sel;
    assign w_finish     = ch_done | ch_error;

    dmac_rr_picker #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_picker (
        .i_req   (w_eligible),
        .i_base  (r_rr_ptr),
        .i_mode  (rr_mode),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; in REQ_BUS a withdrawn request beats a same-cycle grant.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_win_valid) w_next_state = REQ_BUS;
            REQ_BUS: begin
                if (!w_eligible[r_ch_sel]) begin
                    w_next_state = IDLE;
                end else if (Bus_Grant) begin
                    w_next_state = START;
                end
            end
            START:   w_next_state = BUSY;
            BUSY:    if (w_finish) w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        Bus_Req  = 1'b0;
        ch_start = 1'b0;
        ReqAck   = '0;
        case (r_state)
            REQ_BUS: Bus_Req  = 1'b1;
            START: begin
                Bus_Req  = 1'b1;
                ch_start = 1'b1;
            end
            BUSY:    Bus_Req  = 1'b1;
            ACK:     ReqAck   = w_sel_onehot;
            default: ;
        endcase
    end

    // Owned channel, round-robin pointer and completion cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch_sel     <= '0;
            r_rr_ptr     <= '0;
            r_cause_done <= 1'b0;
            r_cause_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_win_valid) begin
                r_ch_sel <= w_win_idx;
            end
            if (r_state == BUSY && w_finish) begin
                r_cause_done <= ch_done;
                r_cause_err  <= ch_error;
            end
            if (r_state == ACK) begin
                r_rr_ptr <= (r_ch_sel == CH_W'(NUM_CH - 1)) ? '0 : r_ch_sel + CH_W'(1);
            end
        end
    end

    assign w_done_set = (r_state == ACK && r_cause_done) ? w_sel_onehot : '0;
    assign w_err_set  = (r_state == ACK && r_cause_err)  ? w_sel_onehot : '0;

    // Sticky status with write-1-to-clear; a set in the same cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_sts <= '0;
            r_err_sts  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_done_sts <= (r_done_sts & ~irq_clr) | w_done_set;
            r_err_sts  <= (r_err_sts  & ~irq_clr) | w_err_set;
            r_irq      <= |(r_done_sts | r_err_sts);
        end
    end

    assign ch_sel    = r_ch_sel;
    assign done_sts  = r_done_sts;
    assign err_sts   = r_err_sts;
    assign Interrupt = r_irq;

endmodule
